inst_fetch_queue: RTL and testbench

Instruction prefetch queue between the PC/instruction-memory side and the IF/ID pipeline register. It issues sequential fetches to a possibly multi-cycle instruction memory using a req/ack handshake, and buffers up to DEPTH {pc, instruction} pairs. It hands them to IF/ID with a valid/ready handshake and restarts fetch at a new PC when a branch taken in ID redirects the front end.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/inst_fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry ring buffer of {pc, inst} pairs with clear
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_mem[r_wr_ptr] <= push_entry_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential instruction prefetch queue with redirect
// Optional FETCH_QUEUE_BYPASS_EN: ack data goes straight to the outputs when the queue is empty.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       start_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       imem_req_o,
    output logic [31:0]                imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [31:0]                imem_data_i,
    output logic                       out_valid_o,
    output logic [31:0]                out_pc_o,
    output logic [31:0]                out_inst_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_addr;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_ack_wait;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;
    logic          w_new_req;

    assign w_ack_wait   = (r_state == WAIT) && imem_ack_i && !redirect_i;
    assign w_fifo_valid = (w_count != '0);
    assign w_pop        = w_fifo_valid && out_ready_i && !redirect_i;
    assign w_push_entry = '{pc: r_fetch_pc, inst: imem_data_i};

`ifdef FETCH_QUEUE_BYPASS_EN
    // An entry consumed straight from the bus is never written to storage.
    assign w_bypass = w_ack_wait && !w_fifo_valid;
    assign w_push   = w_ack_wait && !(w_bypass && out_ready_i);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_ack_wait;
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .resetn_i     (start_i),
        .clear_i      (redirect_i),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .head_o       (w_head),
        .count_o      (w_count)
    );

    always_comb begin
        w_count_nxt = w_count;
        if (redirect_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = w_count + CW'(1);
                2'b01:   w_count_nxt = w_count - CW'(1);
                default: w_count_nxt = w_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_i) begin
            case (r_state)
                WAIT:    w_state_nxt = imem_ack_i ? WAIT : KILL;
                KILL:    w_state_nxt = KILL;
                default: w_state_nxt = WAIT;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_count_nxt < FULL) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack_i) begin
                        w_state_nxt = (w_count_nxt < FULL) ? WAIT : IDLE;
                    end
                end
                KILL: begin
                    if (imem_ack_i) begin
                        w_state_nxt = WAIT;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_o  = (r_state == WAIT) || (r_state == KILL);
        imem_addr_o = r_addr;
        out_valid_o = w_fifo_valid || w_bypass;
        out_pc_o    = '0;
        out_inst_o  = '0;
        if (w_fifo_valid) begin
            out_pc_o   = w_head.pc;
            out_inst_o = w_head.inst;
        end else if (w_bypass) begin
            out_pc_o   = r_fetch_pc;
            out_inst_o = imem_data_i;
        end
        count_o = w_count;
    end

    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        if (redirect_i) begin
            w_fetch_pc_nxt = align_pc(redirect_pc_i);
        end else if (w_ack_wait) begin
            w_fetch_pc_nxt = r_fetch_pc + PC_INC;
        end
    end

    // A fresh request starts whenever WAIT is entered from elsewhere or a WAIT request completes.
    assign w_new_req = (w_state_nxt == WAIT) && ((r_state != WAIT) || imem_ack_i);

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_new_req) begin
                r_addr <= w_fetch_pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    localparam logic [31:0] INST_KEY = 32'h5A5A_C3C3;

    logic        clk_i;
    logic        start_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        out_valid_o;
    logic [31:0] out_pc_o;
    logic [31:0] out_inst_o;
    logic        out_ready_i;
    logic [2:0]  count_o;

    int          n_total;
    int          n_pass;
    int          mem_lat;
    int          mem_cnt;
    logic        mon_en;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t tbl [12];

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .out_valid_o   (out_valid_o),
        .out_pc_o      (out_pc_o),
        .out_inst_o    (out_inst_o),
        .out_ready_i   (out_ready_i),
        .count_o       (count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        redirect_i = 1'b0;
        start_i    = 1'b0;
        exp_q.delete();
        repeat (2) cyc();
        start_i = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            cyc();
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Instruction memory: acks after mem_lat wait cycles, shares the reset
    initial begin
        imem_ack_i  = 1'b0;
        imem_data_i = 32'hBAD0_BAD0;
        mem_cnt     = 0;
        forever begin
            @(posedge clk_i);
            #2;
            if (!start_i || !imem_req_o) begin
                imem_ack_i  = 1'b0;
                imem_data_i = 32'hBAD0_BAD0;
                mem_cnt     = 0;
            end else if (mem_cnt >= mem_lat) begin
                imem_ack_i  = 1'b1;
                imem_data_i = imem_addr_o ^ INST_KEY;
                mem_cnt     = 0;
            end else begin
                imem_ack_i  = 1'b0;
                imem_data_i = 32'hBAD0_BAD0;
                mem_cnt++;
            end
        end
    end

    // Scoreboard: every accepted entry must match the next expected PC in order
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (mon_en && start_i && out_valid_o && out_ready_i && !redirect_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc_o, e);
                chk("sb_inst", out_inst_o, e ^ INST_KEY);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_total       = 0;
        n_pass        = 0;
        mem_lat       = 0;
        mon_en        = 1'b0;
        start_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        out_ready_i   = 1'b0;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 3'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 3'd2};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 3'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 3'd4};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 3'd3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 3'd3};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 3'd3};

        // Reset state, then zero-wait fill under back-pressure and drain
        repeat (3) cyc();
        @(negedge clk_i);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_inst", out_inst_o, 32'h0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        cyc();
        mon_en = 1'b1;
        exp_q  = {32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
        for (int i = 0; i < 12; i++) begin
            start_i     = tbl[i].start;
            out_ready_i = tbl[i].ready;
            @(negedge clk_i);
            chk($sformatf("t%0d_req", i), 32'(imem_req_o), 32'(tbl[i].exp_req));
            chk($sformatf("t%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].exp_valid));
            chk($sformatf("t%0d_pc", i), out_pc_o, tbl[i].exp_pc);
            chk($sformatf("t%0d_count", i), 32'(count_o), 32'(tbl[i].exp_count));
            cyc();
        end
        wait_empty("fill_drain");

        // 3-wait memory, redirect in the second wait cycle: stale data dropped
        mem_lat     = 3;
        out_ready_i = 1'b1;
        do_reset();
        mon_en = 1'b1;
        exp_q  = {32'h100, 32'h104};
        cyc();
        cyc();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("kill_req", 32'(imem_req_o), 32'd1);
        chk("kill_addr", imem_addr_o, 32'h0);
        chk("kill_count", 32'(count_o), 32'd0);
        cyc();
        cyc();
        @(negedge clk_i);
        chk("kill_new_addr", imem_addr_o, 32'h100);
        chk("kill_valid", 32'(out_valid_o), 32'd0);
        cyc();
        wait_empty("kill_drain");

        // Redirect with 3 queued while pop and ack coincide
        mem_lat     = 0;
        out_ready_i = 1'b0;
        do_reset();
        mon_en = 1'b1;
        exp_q  = {32'h40, 32'h44, 32'h48};
        repeat (4) cyc();
        out_ready_i   = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(negedge clk_i);
        chk("rd3_count_before", 32'(count_o), 32'd3);
        chk("rd3_ack", 32'(imem_ack_i & imem_req_o), 32'd1);
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("rd3_count_after", 32'(count_o), 32'd0);
        chk("rd3_valid_after", 32'(out_valid_o), 32'd0);
        chk("rd3_addr", imem_addr_o, 32'h40);
        cyc();
        wait_empty("rd3_drain");

        // Address wrap, low bits of the target ignored, one entry per cycle
        mon_en = 1'b0;
        exp_q.delete();
        cyc();
        mon_en        = 1'b1;
        exp_q         = {32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        cyc();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk_i);
        chk("wrap_pc0", out_pc_o, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk_i);
        chk("wrap_pc1", out_pc_o, 32'h0000_0000);
        cyc();
        wait_empty("wrap_drain");

        // Reset for one cycle while a request is outstanding
        mon_en = 1'b0;
        exp_q.delete();
        mem_lat = 3;
        repeat (2) cyc();
        @(negedge clk_i);
        chk("mid_req_before", 32'(imem_req_o), 32'd1);
        cyc();
        start_i = 1'b0;
        cyc();
        start_i = 1'b1;
        @(negedge clk_i);
        chk("mid_req", 32'(imem_req_o), 32'd0);
        chk("mid_count", 32'(count_o), 32'd0);
        chk("mid_valid", 32'(out_valid_o), 32'd0);
        mon_en = 1'b1;
        exp_q  = {32'h0, 32'h4};
        cyc();
        @(negedge clk_i);
        chk("mid_restart_req", 32'(imem_req_o), 32'd1);
        chk("mid_restart_addr", imem_addr_o, 32'h0);
        cyc();
        wait_empty("mid_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
